// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   ARCH_LEN / INST_LEN  : address and instruction widths
//   NOP_INST             : bubble presented to decode when no instruction is valid
//   FETCH_BUF_DEPTH      : default instruction buffer depth
//   fetch_state_t        : request FSM states
//   fetch_buf_entry_t    : one buffered instruction with its PC
package fetch_stage_pkg;

   localparam int ARCH_LEN = 32;
   localparam int INST_LEN = 32;

   localparam logic [INST_LEN-1:0] NOP_INST        = 32'h0000_0013;
   localparam int                  FETCH_BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [INST_LEN-1:0] inst;
      logic [ARCH_LEN-1:0] pc;
   } fetch_buf_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory channel between fetch (master) and instruction memory (slave).
//   req_valid / req_ready / req_addr : word read request, valid/ready handshake
//   rsp_valid / rsp_data             : in-order response, one per accepted request
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic [ARCH_LEN-1:0] req_addr;
   logic                rsp_valid;
   logic [INST_LEN-1:0] rsp_data;

   modport master (output req_valid, req_addr, input  req_ready, rsp_valid, rsp_data);
   modport slave  (input  req_valid, req_addr, output req_ready, rsp_valid, rsp_data);

endinterface

// File: rtl/fetch_stage_buffer.sv
// Fetch instruction buffer: synchronous FIFO of fetch_buf_entry_t.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write one entry
//   pop              : drop the head entry (caller guarantees non-empty)
//   flush            : empty the FIFO; wins over push and pop
//   head             : current head entry (combinational)
//   count            : number of valid entries
module fetch_stage_buffer
   import fetch_stage_pkg::*;
#(
   parameter  int DEPTH = FETCH_BUF_DEPTH,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_buf_entry_t push_data,
   input  logic             pop,
   input  logic             flush,
   output fetch_buf_entry_t head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_buf_entry_t   mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory
// (one outstanding at a time), buffers responses and feeds decode. Redirects
// from EXE flush the buffer and retarget the PC; a response belonging to a
// killed request is dropped.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : instruction memory request/response channel (master)
//   redirect_valid/pc : EXE redirect and target (low two bits ignored)
//   stall_dec_in      : decode cannot accept this cycle
//   inst_fetched_out  : buffer head instruction, NOP_INST when not valid
//   fetch_valid_out   : buffer head is valid
//   fetch_pc_out      : PC of buffer head, 0 when not valid
// Build option FETCH_PERF_EN adds saturating counters perf_stall_cnt
// (valid & stalled cycles) and perf_redirect_cnt (redirect cycles).
//
// state | meaning
// IDLE  | no request outstanding; start one when a buffer slot is free
// REQ   | request presented, address held until accepted
// WAIT  | request accepted, response will be buffered
// DROP  | request accepted but killed by a redirect, response discarded
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [ARCH_LEN-1:0] RESET_PC  = '0,
   parameter int                  BUF_DEPTH = FETCH_BUF_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_stage_if.master       imem,
   input  logic                redirect_valid,
   input  logic [ARCH_LEN-1:0] redirect_pc,
   input  logic                stall_dec_in,
   output logic [INST_LEN-1:0] inst_fetched_out,
   output logic                fetch_valid_out,
   output logic [ARCH_LEN-1:0] fetch_pc_out
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]         perf_stall_cnt,
   output logic [31:0]         perf_redirect_cnt
`endif
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t        state;
   logic [ARCH_LEN-1:0] pc;
   logic [ARCH_LEN-1:0] req_pc;
   logic                kill;

   fetch_buf_entry_t    head;
   fetch_buf_entry_t    push_entry;
   logic [CNT_W-1:0]    buf_count;
   logic                buf_push;
   logic                buf_pop;
   logic                req_accept;
   logic [ARCH_LEN-1:0] redirect_pc_al;

   assign redirect_pc_al = {redirect_pc[ARCH_LEN-1:2], 2'b00};
   assign req_accept     = (state == REQ) && imem.req_ready;
   assign buf_push       = (state == WAIT) && imem.rsp_valid && !redirect_valid;
   assign buf_pop        = fetch_valid_out && !stall_dec_in && !redirect_valid;
   assign push_entry     = '{inst: imem.rsp_data, pc: req_pc};

   fetch_stage_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (buf_push),
      .push_data (push_entry),
      .pop       (buf_pop),
      .flush     (redirect_valid),
      .head      (head),
      .count     (buf_count)
   );

   assign fetch_valid_out  = (buf_count != '0);
   assign inst_fetched_out = fetch_valid_out ? head.inst : NOP_INST;
   assign fetch_pc_out     = fetch_valid_out ? head.pc : '0;

   assign imem.req_valid = (state == REQ);
   assign imem.req_addr  = req_pc;

   // Entering REQ only with count < BUF_DEPTH reserves the slot the response
   // will occupy, since only one request is ever in flight. Once a redirect
   // has killed the held request, pc already holds the target and must not
   // be advanced by the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
         kill   <= 1'b0;
      end else begin
         if (redirect_valid)          pc <= redirect_pc_al;
         else if (req_accept && !kill) pc <= pc + ARCH_LEN'(4);

         unique case (state)
            IDLE: begin
               if (!redirect_valid && (buf_count < CNT_W'(BUF_DEPTH))) begin
                  state  <= REQ;
                  req_pc <= pc;
                  kill   <= 1'b0;
               end
            end
            REQ: begin
               if (req_accept)          state <= (kill || redirect_valid) ? DROP : WAIT;
               else if (redirect_valid) kill  <= 1'b1;
            end
            WAIT: begin
               if (imem.rsp_valid)      state <= IDLE;
               else if (redirect_valid) state <= DROP;
            end
            DROP: begin
               if (imem.rsp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt    <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (fetch_valid_out && stall_dec_in && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid && (perf_redirect_cnt != '1))
            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
   end
`endif

   // A response with nothing outstanding is a memory-side protocol error.
   a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      imem.rsp_valid |-> ((state == WAIT) || (state == DROP)));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall_dec_in = 1'b0;
   logic [31:0] inst_fetched_out;
   logic        fetch_valid_out;
   logic [31:0] fetch_pc_out;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_redirect_cnt;
`endif

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem             (imem_bus.master),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .stall_dec_in     (stall_dec_in),
      .inst_fetched_out (inst_fetched_out),
      .fetch_valid_out  (fetch_valid_out),
      .fetch_pc_out     (fetch_pc_out)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt   (perf_stall_cnt),
      .perf_redirect_cnt(perf_redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   bit          mem_ready;
   int          mem_lat;
   bit          pend_valid;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic [31:0] rsp_addr;
   int          n_accept;
   logic [31:0] issued   [$];
   logic [31:0] cons_pc  [$];
   logic [31:0] cons_inst[$];

   function automatic logic [31:0] word_of(input logic [31:0] addr);
      return addr ^ KEY;
   endfunction

   // One clock: record what the coming posedge will do with the values now
   // driven (accept, decode pop), then move to the next negedge and drive
   // the memory model's outputs for the following edge.
   task automatic step();
      if (imem_bus.req_valid && imem_bus.req_ready) begin
         issued.push_back(imem_bus.req_addr);
         pend_valid = 1'b1;
         pend_addr  = imem_bus.req_addr;
         pend_cnt   = mem_lat;
         n_accept++;
      end
      if (fetch_valid_out && !stall_dec_in && !redirect_valid) begin
         cons_pc.push_back(fetch_pc_out);
         cons_inst.push_back(inst_fetched_out);
      end
      @(negedge clk);
      imem_bus.rsp_valid = 1'b0;
      if (pend_valid) begin
         if (pend_cnt == 0) begin
            imem_bus.rsp_valid = 1'b1;
            imem_bus.rsp_data  = word_of(pend_addr);
            rsp_addr           = pend_addr;
            pend_valid         = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      imem_bus.req_ready = mem_ready;
   endtask

   task automatic set_ready(input bit r);
      mem_ready          = r;
      imem_bus.req_ready = r;
   endtask

   task automatic clear_logs();
      issued.delete();
      cons_pc.delete();
      cons_inst.delete();
      n_accept = 0;
   endtask

   task automatic apply_reset();
      rst_n              = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      stall_dec_in       = 1'b0;
      mem_lat            = 0;
      pend_valid         = 1'b0;
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = '0;
      set_ready(1'b1);
      clear_logs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_accept(input string name);
      int budget;
      budget = 0;
      while (n_accept == 0 && budget < 20) begin
         step();
         budget++;
      end
      n_checks++;
      if (n_accept == 0) begin
         n_errors++;
         $display("FAIL %s_accept_timeout: accepts=%0d required>=1", name, n_accept);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (5) step();
      rst_n              = 1'b0;
      pend_valid         = 1'b0;
      imem_bus.rsp_valid = 1'b0;
      #1;
      n_checks++;
      if (imem_bus.req_valid !== 1'b0 || fetch_valid_out !== 1'b0 ||
          inst_fetched_out !== NOP_INST || fetch_pc_out !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: req_valid=%b valid=%b inst=%h pc=%h required 0 0 %h 0",
                  imem_bus.req_valid, fetch_valid_out, inst_fetched_out, fetch_pc_out, NOP_INST);
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if (perf_stall_cnt !== 32'h0 || perf_redirect_cnt !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_perf: stall=%0d redirect=%0d required 0 0", perf_stall_cnt, perf_redirect_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      step();
      n_checks++;
      if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_first_req: req_valid=%b addr=%h required 1 00000000",
                  imem_bus.req_valid, imem_bus.req_addr);
      end
   endtask

   task automatic test_stream();
      logic        prev_rsp;
      logic [31:0] prev_addr;
      apply_reset();
      for (int k = 0; k < 40; k++) begin
         prev_rsp  = imem_bus.rsp_valid;
         prev_addr = rsp_addr;
         step();
         n_checks++;
         if (prev_rsp) begin
            if (fetch_valid_out !== 1'b1 || fetch_pc_out !== prev_addr ||
                inst_fetched_out !== word_of(prev_addr)) begin
               n_errors++;
               $display("FAIL stream_latency: valid=%b pc=%h inst=%h required 1 %h %h",
                        fetch_valid_out, fetch_pc_out, inst_fetched_out, prev_addr, word_of(prev_addr));
            end
         end else if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP_INST || fetch_pc_out !== 32'h0) begin
            n_errors++;
            $display("FAIL stream_bubble: valid=%b inst=%h pc=%h required 0 %h 0",
                     fetch_valid_out, inst_fetched_out, fetch_pc_out, NOP_INST);
         end
      end
      n_checks++;
      if (issued.size() < 10 || cons_pc.size() < 10) begin
         n_errors++;
         $display("FAIL stream_count: issued=%0d consumed=%0d required >=10 each", issued.size(), cons_pc.size());
      end
      for (int i = 0; i < issued.size(); i++) begin
         n_checks++;
         if (issued[i] !== 32'(i * 4)) begin
            n_errors++;
            $display("FAIL stream_addr[%0d]: got %h required %h", i, issued[i], 32'(i * 4));
         end
      end
      for (int i = 0; i < cons_pc.size(); i++) begin
         n_checks++;
         if (cons_pc[i] !== 32'(i * 4) || cons_inst[i] !== word_of(32'(i * 4))) begin
            n_errors++;
            $display("FAIL stream_word[%0d]: pc=%h inst=%h required %h %h",
                     i, cons_pc[i], cons_inst[i], 32'(i * 4), word_of(32'(i * 4)));
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      stall_dec_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k >= 4) begin
            n_checks++;
            if (fetch_valid_out !== 1'b1 || fetch_pc_out !== 32'h0 || inst_fetched_out !== word_of(32'h0)) begin
               n_errors++;
               $display("FAIL stall_hold: valid=%b pc=%h inst=%h required 1 00000000 %h",
                        fetch_valid_out, fetch_pc_out, inst_fetched_out, word_of(32'h0));
            end
         end
      end
      n_checks++;
      if (n_accept !== 2 || cons_pc.size() !== 0) begin
         n_errors++;
         $display("FAIL stall_requests: accepts=%0d consumed=%0d required 2 0", n_accept, cons_pc.size());
      end
      stall_dec_in = 1'b0;
      repeat (30) step();
      n_checks++;
      if (cons_pc.size() < 6) begin
         n_errors++;
         $display("FAIL stall_release_count: consumed=%0d required >=6", cons_pc.size());
      end
      for (int i = 0; i < cons_pc.size(); i++) begin
         n_checks++;
         if (cons_pc[i] !== 32'(i * 4) || cons_inst[i] !== word_of(32'(i * 4))) begin
            n_errors++;
            $display("FAIL stall_order[%0d]: pc=%h inst=%h required %h %h",
                     i, cons_pc[i], cons_inst[i], 32'(i * 4), word_of(32'(i * 4)));
         end
      end
   endtask

   task automatic test_flush_full();
      apply_reset();
      stall_dec_in = 1'b1;
      repeat (12) step();
      do_redirect(32'h0000_0040);
      n_checks++;
      if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP_INST) begin
         n_errors++;
         $display("FAIL flush_full: valid=%b inst=%h required 0 %h", fetch_valid_out, inst_fetched_out, NOP_INST);
      end
      clear_logs();
      stall_dec_in = 1'b0;
      repeat (20) step();
      n_checks++;
      if (cons_pc.size() < 2 || cons_pc[0] !== 32'h40 || cons_pc[1] !== 32'h44) begin
         n_errors++;
         $display("FAIL flush_restart: n=%0d first=%h required >=2 starting 00000040",
                  cons_pc.size(), (cons_pc.size() > 0) ? cons_pc[0] : 32'hx);
      end
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      mem_lat = 2;
      wait_accept("redir_wait");
      clear_logs();
      do_redirect(32'h0000_0100);
      for (int k = 0; k < 20; k++) begin
         step();
         n_checks++;
         if (fetch_valid_out === 1'b1 ? (fetch_pc_out !== 32'h100 && cons_pc.size() == 0)
                                      : (inst_fetched_out !== NOP_INST)) begin
            n_errors++;
            $display("FAIL redir_wait_output: valid=%b pc=%h inst=%h required NOP or pc 00000100",
                     fetch_valid_out, fetch_pc_out, inst_fetched_out);
         end
      end
      n_checks++;
      if (issued.size() < 1 || issued[0] !== 32'h100) begin
         n_errors++;
         $display("FAIL redir_wait_addr: n=%0d first=%h required 00000100",
                  issued.size(), (issued.size() > 0) ? issued[0] : 32'hx);
      end
      n_checks++;
      if (cons_pc.size() < 1 || cons_pc[0] !== 32'h100 || cons_inst[0] !== word_of(32'h100)) begin
         n_errors++;
         $display("FAIL redir_wait_word: n=%0d pc=%h required 00000100",
                  cons_pc.size(), (cons_pc.size() > 0) ? cons_pc[0] : 32'hx);
      end
   endtask

   task automatic test_redirect_rsp();
      apply_reset();
      wait_accept("redir_rsp");
      clear_logs();
      do_redirect(32'h0000_0200);
      n_checks++;
      if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP_INST || fetch_pc_out !== 32'h0) begin
         n_errors++;
         $display("FAIL redir_rsp_discard: valid=%b inst=%h pc=%h required 0 %h 0",
                  fetch_valid_out, inst_fetched_out, fetch_pc_out, NOP_INST);
      end
      repeat (15) step();
      n_checks++;
      if (issued.size() < 1 || issued[0] !== 32'h200 || cons_pc.size() < 1 || cons_pc[0] !== 32'h200) begin
         n_errors++;
         $display("FAIL redir_rsp_restart: issued=%0d consumed=%0d first_pc=%h required 00000200",
                  issued.size(), cons_pc.size(), (cons_pc.size() > 0) ? cons_pc[0] : 32'hx);
      end
   endtask

   task automatic test_ready_low();
      apply_reset();
      set_ready(1'b0);
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h0 || n_accept !== 0) begin
            n_errors++;
            $display("FAIL ready_low_hold: req_valid=%b addr=%h accepts=%0d required 1 00000000 0",
                     imem_bus.req_valid, imem_bus.req_addr, n_accept);
         end
      end
      set_ready(1'b1);
      step();
      set_ready(1'b0);
      n_checks++;
      if (n_accept !== 1 || imem_bus.req_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL ready_low_accept: accepts=%0d req_valid=%b required 1 0", n_accept, imem_bus.req_valid);
      end
      repeat (6) step();
      n_checks++;
      if (n_accept !== 1 || imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h4) begin
         n_errors++;
         $display("FAIL ready_low_next: accepts=%0d req_valid=%b addr=%h required 1 1 00000004",
                  n_accept, imem_bus.req_valid, imem_bus.req_addr);
      end
   endtask

   task automatic test_redirect_req();
      apply_reset();
      set_ready(1'b0);
      step();
      do_redirect(32'h0000_0103);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (imem_bus.req_valid !== 1'b1 || imem_bus.req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL redir_req_hold: req_valid=%b addr=%h required 1 00000000",
                     imem_bus.req_valid, imem_bus.req_addr);
         end
         step();
      end
      set_ready(1'b1);
      repeat (20) step();
      n_checks++;
      if (issued.size() < 2 || issued[0] !== 32'h0 || issued[1] !== 32'h100) begin
         n_errors++;
         $display("FAIL redir_req_addrs: n=%0d second=%h required 00000000 then 00000100",
                  issued.size(), (issued.size() > 1) ? issued[1] : 32'hx);
      end
      n_checks++;
      if (cons_pc.size() < 1 || cons_pc[0] !== 32'h100 || cons_inst[0] !== word_of(32'h100)) begin
         n_errors++;
         $display("FAIL redir_req_word: n=%0d first_pc=%h required 00000100",
                  cons_pc.size(), (cons_pc.size() > 0) ? cons_pc[0] : 32'hx);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      do_redirect(32'hFFFF_FFFC);
      repeat (20) step();
      n_checks++;
      if (issued.size() < 3 || issued[0] !== 32'hFFFF_FFFC || issued[1] !== 32'h0 || issued[2] !== 32'h4) begin
         n_errors++;
         $display("FAIL wrap_addrs: n=%0d a0=%h a1=%h required fffffffc 00000000 00000004",
                  issued.size(), (issued.size() > 0) ? issued[0] : 32'hx, (issued.size() > 1) ? issued[1] : 32'hx);
      end
      n_checks++;
      if (cons_pc.size() < 2 || cons_pc[0] !== 32'hFFFF_FFFC || cons_pc[1] !== 32'h0 ||
          cons_inst[0] !== word_of(32'hFFFF_FFFC)) begin
         n_errors++;
         $display("FAIL wrap_words: n=%0d p0=%h required fffffffc then 00000000",
                  cons_pc.size(), (cons_pc.size() > 0) ? cons_pc[0] : 32'hx);
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      apply_reset();
      stall_dec_in = 1'b1;
      repeat (12) step();
      stall_dec_in = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      step();
      redirect_valid = 1'b0;
      step();
      n_checks++;
      if (perf_stall_cnt !== 32'd9 || perf_redirect_cnt !== 32'd2) begin
         n_errors++;
         $display("FAIL perf_counts: stall=%0d redirect=%0d required 9 2", perf_stall_cnt, perf_redirect_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush_full();
      test_redirect_wait();
      test_redirect_rsp();
      test_ready_low();
      test_redirect_req();
      test_wrap();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
